// File: rtl/miner_job_ctrl_if.sv
// Signal bundle between the mining job controller and its host, hashing cores and result sink.
// slave is the controller's view; master is the surrounding system's view.
interface miner_job_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int JOB_ID_W  = 4
);
  logic                      job_valid;
  logic                      job_ready;
  logic [255:0]              job_midstate;
  logic [511:0]              job_data;
  logic [31:0]               job_nonce_start;
  logic [31:0]               job_span;
  logic [JOB_ID_W-1:0]       job_id;
  logic                      job_abort;

  logic                      core_load;
  logic [255:0]              core_midstate;
  logic [511:0]              core_data;
  logic [NUM_CORES*32-1:0]   core_nonce_base;
  logic [NUM_CORES-1:0]      core_golden_valid;
  logic [NUM_CORES*32-1:0]   core_golden_nonce;

  logic                      res_valid;
  logic                      res_ready;
  logic [31:0]               res_nonce;
  logic [JOB_ID_W-1:0]       res_job_id;
  logic                      job_done;
  logic                      busy;
  logic                      overflow;

  modport slave (
    input  job_valid, job_midstate, job_data, job_nonce_start, job_span, job_id, job_abort,
           core_golden_valid, core_golden_nonce, res_ready,
    output job_ready, core_load, core_midstate, core_data, core_nonce_base,
           res_valid, res_nonce, res_job_id, job_done, busy, overflow
  );

  modport master (
    output job_valid, job_midstate, job_data, job_nonce_start, job_span, job_id, job_abort,
           core_golden_valid, core_golden_nonce, res_ready,
    input  job_ready, core_load, core_midstate, core_data, core_nonce_base,
           res_valid, res_nonce, res_job_id, job_done, busy, overflow
  );
endinterface

// File: rtl/miner_job_ctrl.sv
// Mining job controller: loads a job into NUM_CORES hashing cores, times the nonce sweep,
// and funnels golden-nonce reports through per-core pending registers into a result FIFO.
module miner_job_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int JOB_ID_W   = 4
) (
  input  logic           clk,
  input  logic           reset,
  miner_job_ctrl_if.slave bus
);
  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [JOB_ID_W-1:0] id;
    logic [31:0]         nonce;
  } result_t;

  state_t                  state;
  logic [31:0]             span_q;
  logic [31:0]             remaining;
  logic [JOB_ID_W-1:0]     id_q;
  logic                    core_load_q;
  logic                    job_done_q;
  logic [255:0]            midstate_q;
  logic [511:0]            data_q;
  logic [NUM_CORES*32-1:0] base_q;

  logic [NUM_CORES-1:0]    pend_valid;
  logic [31:0]             pend_nonce [NUM_CORES];
  logic                    overflow_q;

  // Result storage: mem holds queued entries, res_q is the presented head.
  // Together they hold at most FIFO_DEPTH results.
  result_t                 mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [AW:0]             mem_count;
  logic                    res_valid_q;
  result_t                 res_q;

  logic [NUM_CORES-1:0]    capture;
  logic [NUM_CORES-1:0]    drain_oh;
  logic [NUM_CORES-1:0]    drained;
  logic                    drain_any;
  logic [31:0]             drain_nonce;
  logic [AW:0]             occupancy;
  logic                    fifo_full;
  logic                    pop;
  logic                    push;
  logic                    load_out;

  // NOTE: every always_comb output gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    drain_oh    = '0;
    drain_any   = 1'b0;
    drain_nonce = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (pend_valid[i] && !drain_any) begin
        drain_oh[i] = 1'b1;
        drain_any   = 1'b1;
        drain_nonce = pend_nonce[i];
      end
    end
  end

  assign capture   = (state == RUN) ? bus.core_golden_valid : '0;
  assign occupancy = mem_count + {{AW{1'b0}}, res_valid_q};
  assign fifo_full = (occupancy == FULL_COUNT);
  assign pop       = res_valid_q && bus.res_ready;
  assign push      = drain_any && (!fifo_full || pop);
  assign drained   = push ? drain_oh : '0;
  assign load_out  = (mem_count != '0) && (!res_valid_q || pop);

  // NOTE: sequential state uses <= so every register samples pre-edge values on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      span_q      <= '0;
      remaining   <= '0;
      id_q        <= '0;
      core_load_q <= 1'b0;
      job_done_q  <= 1'b0;
      midstate_q  <= '0;
      data_q      <= '0;
      base_q      <= '0;
    end else begin
      core_load_q <= 1'b0;
      job_done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.job_valid) begin
            midstate_q  <= bus.job_midstate;
            data_q      <= bus.job_data;
            span_q      <= bus.job_span;
            id_q        <= bus.job_id;
            for (int i = 0; i < NUM_CORES; i++) begin
              base_q[i*32 +: 32] <= bus.job_nonce_start + bus.job_span * 32'(i);
            end
            core_load_q <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          remaining <= span_q;
          state     <= (span_q == '0) ? FLUSH : RUN;
        end
        RUN: begin
          if (bus.job_abort) begin
            remaining <= '0;
            state     <= FLUSH;
          end else begin
            remaining <= remaining - 32'd1;
            if (remaining == 32'd1) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pend_valid == '0) begin
            job_done_q <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new report beats a same-cycle drain, so the fresher nonce survives in the pending slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_valid <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) pend_nonce[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture[i]) begin
          pend_valid[i] <= 1'b1;
          pend_nonce[i] <= bus.core_golden_nonce[i*32 +: 32];
          if (pend_valid[i] && !drained[i]) overflow_q <= 1'b1;
        end else if (drained[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  // NOTE: storage array has no reset; pointers and mem_count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {id_q, drain_nonce};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load_out) begin
        res_q       <= mem[rd_ptr];
        rd_ptr      <= rd_ptr + 1'b1;
        res_valid_q <= 1'b1;
      end else if (pop) begin
        res_valid_q <= 1'b0;
      end
      case ({push, load_out})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase
    end
  end

  assign bus.job_ready       = (state == IDLE);
  assign bus.busy            = (state != IDLE);
  assign bus.core_load       = core_load_q;
  assign bus.core_midstate   = midstate_q;
  assign bus.core_data       = data_q;
  assign bus.core_nonce_base = base_q;
  assign bus.res_valid       = res_valid_q;
  assign bus.res_nonce       = res_q.nonce;
  assign bus.res_job_id      = res_q.id;
  assign bus.job_done        = job_done_q;
  assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_miner_job_ctrl.sv
// Directed bench for miner_job_ctrl: nonce bases, sweep timing, result ordering,
// back-pressure, overflow, abort and mid-job reset, against hand-computed values.
module tb_miner_job_ctrl;
  localparam logic [255:0] MID  = {4{64'h0123456789ABCDEF}};
  localparam logic [511:0] DATA = {8{64'hFEEDFACECAFEBEEF}};

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cycles;
  int   loads;

  miner_job_ctrl_if #(.NUM_CORES(4), .JOB_ID_W(4)) bus ();

  miner_job_ctrl #(.NUM_CORES(4), .FIFO_DEPTH(2), .JOB_ID_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [31:0] ns, input logic [31:0] sp, input logic [3:0] id);
    check("accept_ready", 128'(bus.job_ready), 128'h1);
    bus.job_valid       = 1'b1;
    bus.job_nonce_start = ns;
    bus.job_span        = sp;
    bus.job_id          = id;
    bus.job_midstate    = MID;
    bus.job_data        = DATA;
    tick();
    bus.job_valid       = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output int n_cyc, output int n_load);
    n_cyc  = 0;
    n_load = 0;
    while (!bus.job_done && n_cyc < limit) begin
      tick();
      n_cyc++;
      if (bus.core_load) n_load++;
    end
  endtask

  initial begin
    reset                 = 1'b1;
    bus.job_valid         = 1'b0;
    bus.job_midstate      = '0;
    bus.job_data          = '0;
    bus.job_nonce_start   = '0;
    bus.job_span          = '0;
    bus.job_id            = '0;
    bus.job_abort         = 1'b0;
    bus.core_golden_valid = '0;
    bus.core_golden_nonce = '0;
    bus.res_ready         = 1'b0;
    repeat (3) tick();

    check("rst_job_ready", 128'(bus.job_ready), 128'h1);
    check("rst_busy",      128'(bus.busy),      128'h0);
    check("rst_res_valid", 128'(bus.res_valid), 128'h0);
    check("rst_overflow",  128'(bus.overflow),  128'h0);
    check("rst_core_load", 128'(bus.core_load), 128'h0);
    reset = 1'b0;
    tick();

    // Basic sweep: span 16 on four cores
    start_job(32'h0E33337A, 32'd16, 4'h5);
    check("j1_core_load", 128'(bus.core_load), 128'h1);
    check("j1_bases", 128'(bus.core_nonce_base), 128'h0E3333AA_0E33339A_0E33338A_0E33337A);
    check("j1_mid_lo", bus.core_midstate[127:0], MID[127:0]);
    check("j1_mid_hi", bus.core_midstate[255:128], MID[255:128]);
    check("j1_data_hi", bus.core_data[511:384], DATA[511:384]);
    check("j1_busy", 128'(bus.busy), 128'h1);
    check("j1_not_ready", 128'(bus.job_ready), 128'h0);
    run_to_done(100, cycles, loads);
    check("j1_done_latency", 128'(cycles), 128'd18);
    check("j1_extra_loads", 128'(loads), 128'd0);
    tick();
    check("j1_done_pulse", 128'(bus.job_done), 128'h0);
    check("j1_idle_ready", 128'(bus.job_ready), 128'h1);
    check("j1_idle_busy", 128'(bus.busy), 128'h0);

    // Zero span skips RUN
    start_job(32'h12345678, 32'd0, 4'h1);
    run_to_done(20, cycles, loads);
    check("span0_latency", 128'(cycles), 128'd2);
    tick();

    // Base wrap-around
    start_job(32'hFFFFFFF0, 32'h10, 4'h2);
    check("wrap_bases", 128'(bus.core_nonce_base), 128'h00000020_00000010_00000000_FFFFFFF0);
    run_to_done(100, cycles, loads);
    check("wrap_latency", 128'(cycles), 128'd18);
    tick();

    // Same-cycle reports on cores 2 and 0, plus a LOAD-time report that must be dropped
    bus.res_ready = 1'b1;
    start_job(32'h00001000, 32'd20, 4'h9);
    bus.core_golden_valid = 4'b1000;
    bus.core_golden_nonce = {32'hDEADBEEF, 96'h0};
    tick();
    bus.core_golden_valid = 4'b0101;
    bus.core_golden_nonce = {32'h0, 32'hCCCC0002, 32'h0, 32'hAAAA0000};
    tick();
    bus.core_golden_valid = '0;
    tick();
    check("ord_t1_empty", 128'(bus.res_valid), 128'h0);
    tick();
    check("ord_t2_valid", 128'(bus.res_valid), 128'h1);
    check("ord_t2_nonce", 128'(bus.res_nonce), 128'hAAAA0000);
    check("ord_t2_id", 128'(bus.res_job_id), 128'h9);
    tick();
    check("ord_t3_valid", 128'(bus.res_valid), 128'h1);
    check("ord_t3_nonce", 128'(bus.res_nonce), 128'hCCCC0002);
    check("ord_t3_id", 128'(bus.res_job_id), 128'h9);
    tick();
    check("ord_t4_empty", 128'(bus.res_valid), 128'h0);
    run_to_done(100, cycles, loads);
    check("ord_done", 128'(cycles), 128'd16);
    tick();

    // Back-pressure: depth-2 FIFO, three hits, then double report on core 1
    bus.res_ready = 1'b0;
    start_job(32'h0, 32'd30, 4'h3);
    tick();
    bus.core_golden_valid = 4'b0111;
    bus.core_golden_nonce = {32'h0, 32'h102, 32'h101, 32'h100};
    tick();
    bus.core_golden_valid = '0;
    tick();
    tick();
    check("bp_t2_valid", 128'(bus.res_valid), 128'h1);
    check("bp_t2_nonce", 128'(bus.res_nonce), 128'h100);
    check("bp_t2_id", 128'(bus.res_job_id), 128'h3);
    tick();
    check("bp_no_overflow", 128'(bus.overflow), 128'h0);
    bus.core_golden_valid = 4'b0010;
    bus.core_golden_nonce = {64'h0, 32'h201, 32'h0};
    tick();
    check("ovf_first_ok", 128'(bus.overflow), 128'h0);
    bus.core_golden_nonce = {64'h0, 32'h202, 32'h0};
    tick();
    bus.core_golden_valid = '0;
    check("ovf_set", 128'(bus.overflow), 128'h1);
    repeat (30) tick();
    check("flush_wait_busy", 128'(bus.busy), 128'h1);
    check("flush_wait_head", 128'(bus.res_nonce), 128'h100);
    bus.res_ready = 1'b1;
    tick();
    check("drain_e1", 128'(bus.res_nonce), 128'h101);
    tick();
    check("drain_e2", 128'(bus.res_nonce), 128'h202);
    tick();
    check("drain_e3", 128'(bus.res_nonce), 128'h102);
    check("drain_e3_valid", 128'(bus.res_valid), 128'h1);
    check("drain_done", 128'(bus.job_done), 128'h1);
    tick();
    check("drain_empty", 128'(bus.res_valid), 128'h0);
    check("drain_ready", 128'(bus.job_ready), 128'h1);
    check("ovf_sticky", 128'(bus.overflow), 128'h1);

    // Abort sampled in RUN cycle 3 of a 100-nonce span
    start_job(32'h5000, 32'd100, 4'hA);
    repeat (3) tick();
    bus.job_abort = 1'b1;
    tick();
    bus.job_abort = 1'b0;
    check("abort_flush_busy", 128'(bus.busy), 128'h1);
    check("abort_flush_done0", 128'(bus.job_done), 128'h0);
    tick();
    check("abort_done", 128'(bus.job_done), 128'h1);
    tick();
    check("abort_done_pulse", 128'(bus.job_done), 128'h0);
    check("abort_ready", 128'(bus.job_ready), 128'h1);

    // Reset in the middle of RUN with a result queued and overflow still set
    bus.res_ready = 1'b0;
    start_job(32'h7000, 32'd50, 4'h7);
    tick();
    bus.core_golden_valid = 4'b1000;
    bus.core_golden_nonce = {32'h77, 96'h0};
    tick();
    bus.core_golden_valid = '0;
    tick();
    tick();
    check("pre_rst_valid", 128'(bus.res_valid), 128'h1);
    check("pre_rst_nonce", 128'(bus.res_nonce), 128'h77);
    check("pre_rst_ovf", 128'(bus.overflow), 128'h1);
    reset = 1'b1;
    tick();
    check("mid_rst_ready", 128'(bus.job_ready), 128'h1);
    check("mid_rst_busy", 128'(bus.busy), 128'h0);
    check("mid_rst_res_valid", 128'(bus.res_valid), 128'h0);
    check("mid_rst_res_nonce", 128'(bus.res_nonce), 128'h0);
    check("mid_rst_overflow", 128'(bus.overflow), 128'h0);
    check("mid_rst_core_load", 128'(bus.core_load), 128'h0);
    check("mid_rst_job_done", 128'(bus.job_done), 128'h0);
    check("mid_rst_bases", 128'(bus.core_nonce_base), 128'h0);
    check("mid_rst_mid", bus.core_midstate[127:0], 128'h0);
    reset = 1'b0;
    tick();
    start_job(32'h0, 32'd0, 4'h1);
    run_to_done(20, cycles, loads);
    check("post_rst_span0", 128'(cycles), 128'd2);
    check("post_rst_no_res", 128'(bus.res_valid), 128'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
